// File: rtl/nr_divider_64bit.sv
// nr_divider_64bit
//
// Sequential non-restoring divider: one quotient bit per clock, truncation
// toward zero, remainder carrying the sign of the dividend.
//
// Optional feature macro: NR_DIV_SIGNED_EN
//   defined   -> operands/results are two's complement (magnitude divide
//                plus sign fix-up)
//   undefined -> operands/results are unsigned
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, accepted only while ready=1
//   dividend   numerator, sampled on the accepting edge
//   divisor    denominator, sampled on the accepting edge
//   ready      idle and able to accept start
//   valid      one-cycle pulse, results updated in that cycle
//   quotient   result quotient, held until the next valid
//   remainder  result remainder, held until the next valid
//   div_zero   divisor was zero, held with the result
//
// Latency from the accepting edge k: valid in the cycle after edge k+W+2
// (k+1 for a zero divisor).

module nr_divider_64bit #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         ready,
    output logic         valid,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_zero
);

`ifdef NR_DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    localparam int            CW      = $clog2(W + 1);
    localparam logic [CW-1:0] STEPS   = CW'(W);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [W-1:0]  ONE_W   = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [W-1:0] negate(input logic [W-1:0] x);
        return (~x) + ONE_W;
    endfunction

    // In unsigned builds the operand is already its own magnitude.
    function automatic logic [W-1:0] magnitude(input logic [W-1:0] x);
        if (SIGNED_EN && x[W-1]) begin
            return negate(x);
        end
        return x;
    endfunction

    state_t               state;
    state_t               state_next;
    logic [CW-1:0]        count;
    logic                 dz;

    logic signed [W:0]    p;
    logic [W-1:0]         q;
    logic [W-1:0]         d;
    logic                 q_neg;
    logic                 r_neg;

    logic                 accept;
    logic                 divisor_zero;
    logic signed [W:0]    p_shift;
    logic signed [W:0]    d_ext;
    logic signed [W:0]    p_step;
    logic [W-1:0]         q_step;
    logic [W-1:0]         rem_mag;
    logic [W-1:0]         q_res;
    logic [W-1:0]         r_res;

    always_comb begin
        ready        = (state == IDLE);
        accept       = ready && start;
        divisor_zero = (divisor == '0);
    end

    // One non-restoring step. The add/subtract decision uses the sign of P
    // before the shift: the shifted value may transiently exceed the W+1-bit
    // signed range, but the post-step P always fits, so the wrapped result
    // is exact.
    always_comb begin
        p_shift = {p[W-1:0], q[W-1]};
        d_ext   = {1'b0, d};
        if (p[W]) begin
            p_step = p_shift + d_ext;
        end else begin
            p_step = p_shift - d_ext;
        end
        q_step = {q[W-2:0], ~p_step[W]};
    end

    // Final restore of a negative partial remainder, then sign fix-up. The
    // restored remainder lies in [0, |divisor|), so W-bit arithmetic suffices.
    always_comb begin
        if (p[W]) begin
            rem_mag = p[W-1:0] + d;
        end else begin
            rem_mag = p[W-1:0];
        end
        q_res = q_neg ? negate(q) : q;
        r_res = r_neg ? negate(rem_mag) : rem_mag;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = divisor_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (count == CNT_ONE) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control and result registers: cleared by reset so an abort leaves the
    // outputs at their idle values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            dz        <= 1'b0;
            valid     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            state <= state_next;
            valid <= (state == DONE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        dz    <= divisor_zero;
                        count <= divisor_zero ? '0 : STEPS;
                    end
                end
                CALC: begin
                    count <= count - CNT_ONE;
                end
                DONE: begin
                    // On a zero divisor q still holds the raw dividend.
                    quotient  <= dz ? '1 : q;
                    remainder <= dz ? q : p[W-1:0];
                    div_zero  <= dz;
                end
                default: ;
            endcase
        end
    end

    // Datapath registers: always loaded before use, so no reset needed.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (accept) begin
                    p     <= '0;
                    q     <= divisor_zero ? dividend : magnitude(dividend);
                    d     <= magnitude(divisor);
                    q_neg <= SIGNED_EN && (dividend[W-1] ^ divisor[W-1]);
                    r_neg <= SIGNED_EN && dividend[W-1];
                end
            end
            CALC: begin
                p <= p_step;
                q <= q_step;
            end
            FIX: begin
                p <= {1'b0, r_res};
                q <= q_res;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_nr_divider_64bit.sv
module tb_nr_divider_64bit;

    localparam int W = 64;
    localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         ready;
    logic         valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    nr_divider_64bit #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .valid     (valid),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           due;
    } exp_t;

    exp_t sbq[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    // Reference: plain language-level division (truncating toward zero,
    // remainder follows dividend sign) plus the documented special cases.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int base);
        exp_t e;
`ifdef NR_DIV_SIGNED_EN
        longint sa;
        longint sb;
`endif
        e.dz = 1'b0;
        if (b == '0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
`ifdef NR_DIV_SIGNED_EN
            sa = a;
            sb = b;
            if (a == MIN_V && b == '1) begin
                e.q = MIN_V;
                e.r = '0;
            end else begin
                e.q = sa / sb;
                e.r = sa % sb;
            end
`else
            e.q = a / b;
            e.r = a % b;
`endif
        end
        e.due = base + (e.dz ? 1 : W + 2);
        return e;
    endfunction

    function automatic logic [W-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Monitor: every valid pulse must match the oldest outstanding request.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid at cycle %0d q=%h r=%h", cyc, quotient, remainder);
            end else begin
                e = sbq.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check1("div_zero", div_zero, e.dz);
                check("latency_cycle", W'(cyc), W'(e.due));
                check1("ready_at_valid", ready, 1'b1);
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        while (!ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 required=1");
            return;
        end
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        sbq.push_back(model(a, b, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        check1("ready_fall", ready, 1'b0);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        check1("rst_ready", ready, 1'b1);
        check1("rst_valid", valid, 1'b0);
        check("rst_quotient", quotient, '0);
        check("rst_remainder", remainder, '0);
        check1("rst_div_zero", div_zero, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases
        issue(64'd100, 64'd7);
        issue(-64'd100, 64'd7);
        issue(64'd100, -64'd7);
        issue(MIN_V, '1);
        issue(64'h1234, '0);
        issue('1, 64'd2);
        issue(64'd0, 64'd5);
        issue(64'd5, '1);
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        issue(MIN_V, 64'd3);

        // start pulsed mid-CALC with other operands must be ignored
        issue(64'd1000, 64'd33);
        repeat (20) @(negedge clk);
        start    = 1'b1;
        dividend = rnd64();
        divisor  = 64'd1;
        @(negedge clk);
        start = 1'b0;

        // start held high across a whole operation and its valid cycle
        n = 0;
        while (!ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        a = rnd64();
        b = rnd64() >> 40;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        sbq.push_back(model(a, b, cyc + 1));
        @(negedge clk);
        n = 0;
        while (!ready && n < 300) begin
            dividend = rnd64();
            divisor  = rnd64();
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL held_start_timeout actual=0 required=1");
        end
        a = rnd64();
        b = 64'd12345;
        dividend = a;
        divisor  = b;
        sbq.push_back(model(a, b, cyc + 1));
        @(negedge clk);
        start = 1'b0;

        // Reset in the middle of CALC aborts the operation
        issue(rnd64(), 64'd77);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        sbq.delete();
        #2;
        check1("abort_ready", ready, 1'b1);
        check1("abort_valid", valid, 1'b0);
        check("abort_quotient", quotient, '0);
        check("abort_remainder", remainder, '0);
        check1("abort_div_zero", div_zero, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        issue(64'd9, 64'd3);

        // Randomized operand pairs, back-to-back
        for (int i = 0; i < 1000; i++) begin
            a = rnd64();
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin
                    b = W'($urandom_range(1, 15));
                    if ($urandom_range(0, 1) == 1) b = ~b + 64'd1;
                end
                2: begin
                    a = MIN_V;
                    b = '1;
                end
                3: b = rnd64() >> $urandom_range(1, 62);
                4: b = '1;
                default: b = rnd64();
            endcase
            issue(a, b);
        end

        // Drain outstanding results
        n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout outstanding=%0d required=0", sbq.size());
        end
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
